// File: rtl/cpu_mem_pkg.sv
// Shared constants for the CPU memory/IO bridge: MMIO register map, STATUS layout
// and default parameter values.
package cpu_mem_pkg;

    localparam int unsigned DEF_RAM_WORDS  = 1024;
    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam logic [31:0] DEF_MMIO_BASE  = 32'hFFFF_0000;

    localparam int unsigned TX_OFF   = 0;
    localparam int unsigned STAT_OFF = 1;
    localparam int unsigned RX_OFF   = 2;

    localparam int unsigned STAT_TX_FULL = 0;
    localparam int unsigned STAT_RX_FULL = 1;
    localparam int unsigned STAT_BUS_ERR = 2;
    localparam int unsigned STAT_CNT_LSB = 4;
    localparam int unsigned STAT_CNT_W   = 4;
    localparam int unsigned STAT_CNT_MAX = (1 << STAT_CNT_W) - 1;

    // Assemble the STATUS word; the TX count field saturates rather than wrapping.
    function automatic logic [31:0] stat_word(input logic        tx_full,
                                              input logic        rx_full,
                                              input logic        err,
                                              input logic [31:0] count);
        logic [31:0] w;
        w = '0;
        w[STAT_TX_FULL] = tx_full;
        w[STAT_RX_FULL] = rx_full;
        w[STAT_BUS_ERR] = err;
        w[STAT_CNT_LSB +: STAT_CNT_W] = (count > STAT_CNT_MAX) ? STAT_CNT_W'(STAT_CNT_MAX)
                                                               : count[STAT_CNT_W-1:0];
        return w;
    endfunction

endpackage

// File: rtl/cpu_mem_bridge_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push while full is accepted only
// alongside a pop in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        count   = wr_ptr - rd_ptr;
        empty   = (wr_ptr == rd_ptr);
        full    = (count == FULL_CNT);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        rdata   = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridge between the CPU core and main RAM plus a small MMIO window holding a TX
// FIFO toward the host, an RX holding register from the host and a sticky error flag.
module cpu_mem_bridge
    import cpu_mem_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = DEF_RAM_WORDS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        bus_err
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [RAM_WORDS];
    logic              is_ram;
    logic              is_tx;
    logic              is_stat;
    logic              is_rx;
    logic              is_unmapped;

    logic              tx_push;
    logic              tx_drop;
    logic              tx_full;
    logic              tx_empty;
    logic [CNT_W-1:0]  tx_count;

    logic              rx_full;
    logic [31:0]       rx_word;
    logic              rx_pop;
    logic              rx_cap;
    logic              err_set;

    // Address decode and access qualification.
    always_comb begin
        is_ram      = (cpu_addr < RAM_WORDS);
        is_tx       = (cpu_addr == MMIO_BASE + 32'(TX_OFF));
        is_stat     = (cpu_addr == MMIO_BASE + 32'(STAT_OFF));
        is_rx       = (cpu_addr == MMIO_BASE + 32'(RX_OFF));
        is_unmapped = ~(is_ram | is_tx | is_stat | is_rx);

        tx_push = cpu_we & is_tx & (~tx_full | tx_ready);
        tx_drop = cpu_we & is_tx & tx_full & ~tx_ready;
        // A simultaneous store wins; the RX pop is a read side effect and is suppressed.
        rx_pop  = cpu_re & ~cpu_we & is_rx & rx_full;
        rx_cap  = rx_valid & ~rx_full;
        err_set = ((cpu_we | cpu_re) & is_unmapped) | tx_drop;
    end

    // Zero-latency read mux; a same-cycle store to RAM is not forwarded.
    always_comb begin
        cpu_rdata = '0;
        if (is_ram) begin
            cpu_rdata = ram[cpu_addr[RAM_AW-1:0]];
        end else if (is_stat) begin
            cpu_rdata = stat_word(tx_full, rx_full, bus_err, 32'(tx_count));
        end else if (is_rx) begin
            cpu_rdata = rx_full ? rx_word : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_we && is_ram) ram[cpu_addr[RAM_AW-1:0]] <= cpu_wdata;
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (tx_push),
        .wdata (cpu_wdata),
        .pop   (tx_ready),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;

    // RX holding register: a pop frees it, the next capture is one edge later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_full <= 1'b0;
            rx_word <= '0;
        end else if (rx_pop) begin
            rx_full <= 1'b0;
        end else if (rx_cap) begin
            rx_full <= 1'b1;
            rx_word <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_err <= 1'b0;
        end else if (err_set) begin
            bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: RAM, TX FIFO overflow/wrap, RX register,
// decode errors and asynchronous reset, checked against scoreboard queues.
module tb_cpu_mem_bridge;
    import cpu_mem_pkg::*;

    localparam logic [31:0] TXA = 32'hFFFF_0000;
    localparam logic [31:0] STA = 32'hFFFF_0001;
    localparam logic [31:0] RXA = 32'hFFFF_0002;

    logic        clk;
    logic        reset_n;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        bus_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] tx_q  [$];
    logic [31:0] rx_q  [$];
    logic [31:0] ram_q [$];

    cpu_mem_bridge dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drain the TX FIFO, comparing every popped word with the scoreboard.
    task automatic drain(input string tag);
        tx_ready = 1'b1;
        for (int n = 0; n < 40 && (tx_q.size() > 0 || tx_valid); n++) begin
            #1;
            if (tx_valid) begin
                if (tx_q.size() == 0) chk({tag, "_extra"}, 32'(tx_valid), 32'd0);
                else                  chk(tag, tx_data, tx_q.pop_front());
            end
            tick();
        end
        chk({tag, "_left"}, 32'(tx_q.size()), 32'd0);
        tx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_we    = 1'b0;
        cpu_re    = 1'b0;
        tx_ready  = 1'b0;
        rx_data   = '0;
        rx_valid  = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        cpu_addr = STA; cpu_re = 1'b1;
        #1;
        chk("rst_status", cpu_rdata, 32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        tick();

        // RAM store/load and read-during-write
        cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'h1111_1111;
        ram_q.push_back(32'h1111_1111);
        tick();
        cpu_wdata = 32'hDEAD_BEEF; cpu_re = 1'b1;
        #1;
        chk("ram_rdw_old", cpu_rdata, ram_q.pop_front());
        ram_q.push_back(32'hDEAD_BEEF);
        tick();
        cpu_we = 1'b0;
        #1;
        chk("ram_load", cpu_rdata, ram_q.pop_front());
        tick();
        cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = 32'd1023; cpu_wdata = 32'h5A5A_0001;
        ram_q.push_back(32'h5A5A_0001);
        tick();
        cpu_we = 1'b0; cpu_re = 1'b1;
        #1;
        chk("ram_top_word", cpu_rdata, ram_q.pop_front());
        chk("ram_no_err", 32'(bus_err), 32'd0);
        tick();

        // TX overflow with host stalled
        cpu_re = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cpu_addr = TXA; cpu_we = 1'b1; cpu_wdata = 32'hA000_0000 + 32'(i);
            if (i < 8) tx_q.push_back(cpu_wdata);
            tick();
        end
        cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = STA;
        #1;
        chk("ovf_status", cpu_rdata, 32'h0000_0085);
        chk("ovf_bus_err", 32'(bus_err), 32'd1);
        chk("ovf_tx_valid", 32'(tx_valid), 32'd1);
        chk("ovf_head", tx_data, tx_q[0]);
        cpu_addr = TXA;
        #1;
        chk("tx_read_zero", cpu_rdata, 32'h0);
        cpu_re = 1'b0;
        tick();
        drain("ovf_drain");
        #1;
        chk("ovf_9th_absent", 32'(tx_valid), 32'd0);
        cpu_addr = STA; cpu_re = 1'b1;
        #1;
        chk("ovf_status_empty", cpu_rdata, 32'h0000_0004);
        reset_n = 1'b0;
        #1;
        chk("rst_clears_err", 32'(bus_err), 32'd0);
        reset_n = 1'b1;
        cpu_re = 1'b0;
        tick();

        // Full FIFO with push and pop in the same cycle, across pointer wrap
        for (int i = 0; i < 8; i++) begin
            cpu_addr = TXA; cpu_we = 1'b1; cpu_wdata = 32'hB000_0000 + 32'(i);
            tx_q.push_back(cpu_wdata);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            tx_ready = 1'b1; cpu_we = 1'b1; cpu_addr = TXA;
            cpu_wdata = 32'hB000_0008 + 32'(k);
            #1;
            chk("wrap_head", tx_data, tx_q.pop_front());
            tx_q.push_back(cpu_wdata);
            tick();
        end
        cpu_we = 1'b0; tx_ready = 1'b0; cpu_addr = STA; cpu_re = 1'b1;
        #1;
        chk("wrap_status", cpu_rdata, 32'h0000_0081);
        chk("wrap_no_err", 32'(bus_err), 32'd0);
        cpu_re = 1'b0;
        tick();
        drain("wrap_order");
        cpu_addr = STA; cpu_re = 1'b1;
        #1;
        chk("wrap_status_empty", cpu_rdata, 32'h0);
        cpu_re = 1'b0;
        tick();

        // RX holding register
        rx_data = 32'h1234_5678; rx_valid = 1'b1;
        #1;
        chk("rx_ready_before", 32'(rx_ready), 32'd1);
        rx_q.push_back(rx_data);
        tick();
        rx_data = 32'hBAD0_BAD0;
        #1;
        chk("rx_ready_full", 32'(rx_ready), 32'd0);
        tick();
        rx_valid = 1'b0; rx_data = '0;
        cpu_addr = STA; cpu_re = 1'b1;
        #1;
        chk("rx_status_full", cpu_rdata, 32'h0000_0002);
        tick();
        cpu_addr = RXA; cpu_we = 1'b1; cpu_wdata = 32'h0;
        #1;
        chk("rx_we_re_data", cpu_rdata, rx_q[0]);
        tick();
        cpu_we = 1'b0; cpu_addr = STA;
        #1;
        chk("rx_we_re_kept", cpu_rdata, 32'h0000_0002);
        tick();
        cpu_addr = RXA;
        #1;
        chk("rx_pop_data", cpu_rdata, rx_q.pop_front());
        tick();
        cpu_addr = STA;
        #1;
        chk("rx_status_clear", cpu_rdata, 32'h0);
        chk("rx_ready_after", 32'(rx_ready), 32'd1);
        cpu_addr = RXA;
        #1;
        chk("rx_empty_read", cpu_rdata, 32'h0);
        tick();
        cpu_re = 1'b0;

        // STATUS write is ignored and not an error
        cpu_we = 1'b1; cpu_addr = STA; cpu_wdata = 32'hFFFF_FFFF;
        tick();
        cpu_we = 1'b0;
        #1;
        chk("stat_write_no_err", 32'(bus_err), 32'd0);

        // Unmapped load sets the sticky error
        cpu_addr = 32'h0001_0000; cpu_re = 1'b1;
        #1;
        chk("unmapped_rdata", cpu_rdata, 32'h0);
        tick();
        cpu_re = 1'b0;
        #1;
        chk("unmapped_err", 32'(bus_err), 32'd1);
        repeat (3) tick();
        chk("err_sticky", 32'(bus_err), 32'd1);
        cpu_addr = 32'd1024; cpu_re = 1'b1;
        #1;
        chk("ram_edge_unmapped", cpu_rdata, 32'h0);
        tick();
        cpu_re = 1'b0;

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) begin
            cpu_addr = TXA; cpu_we = 1'b1; cpu_wdata = 32'hC000_0000 + 32'(i);
            tx_q.push_back(cpu_wdata);
            tick();
        end
        cpu_we = 1'b0; tx_ready = 1'b1;
        #1;
        chk("mid_head0", tx_data, tx_q.pop_front());
        tick();
        #1;
        chk("mid_head1", tx_data, tx_q.pop_front());
        reset_n = 1'b0;
        #1;
        tx_q.delete();
        chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_bus_err", 32'(bus_err), 32'd0);
        chk("mid_rst_rx_ready", 32'(rx_ready), 32'd1);
        tx_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        cpu_addr = STA; cpu_re = 1'b1;
        #1;
        chk("post_rst_status", cpu_rdata, 32'h0);
        tick();
        cpu_re = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
